lsu_access_ctrl: RTL and testbench

Load/store access controller between the pipeline MEM stage and the data memory port. Accepts one load/store request at a time, generates word-aligned address, byte enables and lane-shifted store data, runs the memory request/grant/response handshake, and returns sign/zero-extended load data using the same 3-bit size/sign encoding as the load-extension decoder. Optionally splits misaligned accesses into two word accesses.

---
 rtl/lsu_access_ctrl.sv | 175 +++++++++++++++++
 tb/tb_lsu_access_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_access_ctrl
// Description : Load/store access controller between the MEM stage and the
//               data memory port. LSU_MISALIGN_SPLIT_EN enables two-beat
//               execution of misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_access_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_sel,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam logic [2:0] SEL_BS = 3'b001;
    localparam logic [2:0] SEL_HS = 3'b010;
    localparam logic [2:0] SEL_W  = 3'b011;
    localparam logic [2:0] SEL_BU = 3'b100;
    localparam logic [2:0] SEL_HU = 3'b101;

    logic [2:0]  state, state_nxt;
    logic        lat_we, lat_err, lat_split;
    logic [2:0]  lat_sel;
    logic [31:0] lat_addr, lat_wdata, rdata0, rdata1;

    logic        sel_bad, store_bad, misal, req_illegal;
    logic [7:0]  be_base, be_all;
    logic [63:0] wd_all;
    logic [31:0] ld_x, ld_ext, word_addr;

    // Request classification only feeds the latch, never the memory port.
    always_comb begin
        sel_bad   = (req_sel == 3'b000) || (req_sel == 3'b110) || (req_sel == 3'b111);
        store_bad = req_we && ((req_sel == SEL_BU) || (req_sel == SEL_HU));
        case (req_sel)
            SEL_HS, SEL_HU: misal = (req_addr[1:0] == 2'd3);
            SEL_W:          misal = (req_addr[1:0] != 2'd0);
            default:        misal = 1'b0;
        endcase
        req_illegal = sel_bad || store_bad || (misal && !SPLIT_EN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid) state_nxt = req_illegal ? S_RESP : S_REQ0;
            S_REQ0:  if (mem_gnt) state_nxt = S_WAIT0;
            S_WAIT0: if (mem_rvalid) state_nxt = lat_split ? S_REQ1 : S_RESP;
            S_REQ1:  if (mem_gnt) state_nxt = S_WAIT1;
            S_WAIT1: if (mem_rvalid) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            lat_split <= 1'b0;
            lat_sel   <= 3'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            rdata0    <= 32'd0;
            rdata1    <= 32'd0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_err   <= req_illegal;
                lat_split <= misal && SPLIT_EN && !req_illegal;
                lat_sel   <= req_sel;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                rdata0    <= 32'd0;
                rdata1    <= 32'd0;
            end
            if (state == S_WAIT0 && mem_rvalid) rdata0 <= mem_rdata;
            if (state == S_WAIT1 && mem_rvalid) rdata1 <= mem_rdata;
        end
    end

    // Lane alignment: low halves serve the first beat, high halves the second.
    always_comb begin
        case (lat_sel)
            SEL_BS, SEL_BU: be_base = 8'h01;
            SEL_HS, SEL_HU: be_base = 8'h03;
            default:        be_base = 8'h0F;
        endcase
        be_all    = be_base << lat_addr[1:0];
        wd_all    = {32'd0, lat_wdata} << {lat_addr[1:0], 3'b000};
        ld_x      = 32'({rdata1, rdata0} >> {lat_addr[1:0], 3'b000});
        word_addr = {lat_addr[31:2], 2'b00};
        case (lat_sel)
            SEL_BS:  ld_ext = {{24{ld_x[7]}}, ld_x[7:0]};
            SEL_HS:  ld_ext = {{16{ld_x[15]}}, ld_x[15:0]};
            SEL_W:   ld_ext = ld_x;
            SEL_BU:  ld_ext = {24'd0, ld_x[7:0]};
            SEL_HU:  ld_ext = {16'd0, ld_x[15:0]};
            default: ld_ext = 32'd0;
        endcase
    end

    always_comb begin
        req_ready  = (state == S_IDLE);
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_be     = 4'd0;
        mem_wdata  = 32'd0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        case (state)
            S_REQ0: begin
                mem_req   = 1'b1;
                mem_we    = lat_we;
                mem_addr  = word_addr;
                mem_be    = be_all[3:0];
                mem_wdata = lat_we ? wd_all[31:0] : 32'd0;
            end
            S_REQ1: begin
                mem_req   = 1'b1;
                mem_we    = lat_we;
                mem_addr  = word_addr + 32'd4;
                mem_be    = be_all[7:4];
                mem_wdata = lat_we ? wd_all[63:32] : 32'd0;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = lat_err;
                resp_rdata = (lat_err || lat_we) ? 32'd0 : ld_ext;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_access_ctrl
// Description : Table-driven bench for lsu_access_ctrl with a response
//               scoreboard; honours LSU_MISALIGN_SPLIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_access_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_sel;
    logic [31:0] req_addr, req_wdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    always #5 clk = ~clk;

    lsu_access_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gnt_dly;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          beats;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                                input logic [31:0] wdata, input int gnt_dly,
                                input logic [31:0] rd0, input logic [31:0] rd1, input int beats,
                                input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                                input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
                                input logic [31:0] rdata, input int lat);
        vec_t v;
        v.we = we; v.sel = sel; v.addr = addr; v.wdata = wdata; v.gnt_dly = gnt_dly;
        v.rd0 = rd0; v.rd1 = rd1; v.beats = beats;
        v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
        v.err = 1'b0; v.rdata = rdata; v.lat = lat;
        return v;
    endfunction

    function automatic vec_t mkerr(input logic we, input logic [2:0] sel, input logic [31:0] addr);
        vec_t v;
        v = mk(we, sel, addr, 32'h5A5A5A5A, 0, 0, 0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 32'd0, 1);
        v.err = 1'b1;
        return v;
    endfunction

    // Scoreboard: every completion pulse consumes one expected response.
    always @(negedge clk) begin
        if (reset_n && resp_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: resp_valid=1 with nothing pending, required 0 (t=%0t)", $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
                chk("resp_rdata", resp_rdata, mon_e.rdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: req_ready=%b, required 1", req_ready);
        end
    endtask

    task automatic scramble_req();
        req_we    = 1'($urandom);
        req_sel   = 3'($urandom_range(0, 7));
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic run_txn(input vec_t v);
        int t;
        exp_t e;
        wait_ready();
        req_valid = 1'b1;
        req_we    = v.we;
        req_sel   = v.sel;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        step();
        req_valid = 1'b0;
        scramble_req();
        e.err   = v.err;
        e.rdata = v.rdata;
        sb_q.push_back(e);
        t = 1;
        for (int b = 0; b < v.beats; b++) begin
            for (int d = 0; d <= v.gnt_dly; d++) begin
                chk("mem_req", {31'd0, mem_req}, 32'd1);
                chk("mem_we", {31'd0, mem_we}, {31'd0, v.we});
                chk("mem_addr", mem_addr, (b == 0) ? v.a0 : v.a1);
                chk("mem_be", {28'd0, mem_be}, {28'd0, (b == 0) ? v.be0 : v.be1});
                if (v.we) chk("mem_wdata", mem_wdata, (b == 0) ? v.wd0 : v.wd1);
                if (d == v.gnt_dly) mem_gnt = 1'b1;
                step();
                t++;
                mem_gnt = 1'b0;
            end
            chk("mem_req_wait", {31'd0, mem_req}, 32'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = (b == 0) ? v.rd0 : v.rd1;
            step();
            t++;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        if (v.beats == 0) chk("mem_req_err", {31'd0, mem_req}, 32'd0);
        while (resp_valid !== 1'b1 && t < 12) begin
            step();
            t++;
        end
        chk("latency", t, v.lat);
        step();
        chk("resp_pulse", {31'd0, resp_valid}, 32'd0);
        chk("ready_after", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
    endtask

    initial begin
        exp_t e;
        reset_n = 1'b0; req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        scramble_req();

        vecs.push_back(mk(0, 3'b001, 32'h103, 0, 0, 32'h80FFFFFF, 0, 1, 32'h100, 4'b1000, 0, 0, 0, 0, 32'hFFFFFF80, 3));
        vecs.push_back(mk(0, 3'b101, 32'h202, 0, 0, 32'hBEEF1234, 0, 1, 32'h200, 4'b1100, 0, 0, 0, 0, 32'h0000BEEF, 3));
        vecs.push_back(mk(1, 3'b010, 32'h00A, 32'h0000ABCD, 2, 0, 0, 1, 32'h008, 4'b1100, 32'hABCD0000, 0, 0, 0, 32'd0, 5));
        vecs.push_back(mkerr(1, 3'b100, 32'h10));
        vecs.push_back(mkerr(0, 3'b111, 32'h20));
        vecs.push_back(mkerr(0, 3'b000, 32'h24));
        vecs.push_back(mkerr(1, 3'b101, 32'h30));
        vecs.push_back(mk(1, 3'b011, 32'h40, 32'hDEADBEEF, 1, 0, 0, 1, 32'h40, 4'b1111, 32'hDEADBEEF, 0, 0, 0, 32'd0, 4));
        vecs.push_back(mk(0, 3'b010, 32'h301, 0, 0, 32'h12F0ABCD, 0, 1, 32'h300, 4'b0110, 0, 0, 0, 0, 32'hFFFFF0AB, 3));
        vecs.push_back(mk(0, 3'b100, 32'h402, 0, 0, 32'h00A50000, 0, 1, 32'h400, 4'b0100, 0, 0, 0, 0, 32'h000000A5, 3));
        vecs.push_back(mk(1, 3'b001, 32'h055, 32'h123456AB, 0, 0, 0, 1, 32'h054, 4'b0010, 32'h3456AB00, 0, 0, 0, 32'd0, 3));
        vecs.push_back(mk(0, 3'b010, 32'h102, 0, 0, 32'h7ABC0000, 0, 1, 32'h100, 4'b1100, 0, 0, 0, 0, 32'h00007ABC, 3));
        vecs.push_back(mk(0, 3'b001, 32'h005, 0, 0, 32'h00007F00, 0, 1, 32'h004, 4'b0010, 0, 0, 0, 0, 32'h0000007F, 3));
        vecs.push_back(mk(0, 3'b011, 32'h000, 0, 0, 32'hCAFEF00D, 0, 1, 32'h000, 4'b1111, 0, 0, 0, 0, 32'hCAFEF00D, 3));
`ifdef LSU_MISALIGN_SPLIT_EN
        vecs.push_back(mk(0, 3'b011, 32'h101, 0, 0, 32'h44332211, 32'h88776655, 2, 32'h100, 4'b1110, 0, 32'h104, 4'b0001, 0, 32'h55443322, 5));
        vecs.push_back(mk(0, 3'b010, 32'h1FF, 0, 0, 32'h7F000000, 32'h000000FF, 2, 32'h1FC, 4'b1000, 0, 32'h200, 4'b0001, 0, 32'hFFFFFF7F, 5));
        vecs.push_back(mk(1, 3'b011, 32'hFFFFFFFE, 32'hAABBCCDD, 0, 0, 0, 2, 32'hFFFFFFFC, 4'b1100, 32'hCCDD0000, 32'h0, 4'b0011, 32'h0000AABB, 32'd0, 5));
        vecs.push_back(mk(0, 3'b011, 32'h107, 0, 0, 32'hAA000000, 32'h00DDCCBB, 2, 32'h104, 4'b1000, 0, 32'h108, 4'b0111, 0, 32'hDDCCBBAA, 5));
`else
        vecs.push_back(mkerr(0, 3'b011, 32'h101));
        vecs.push_back(mkerr(0, 3'b010, 32'h1FF));
        vecs.push_back(mkerr(1, 3'b011, 32'hFFFFFFFE));
        vecs.push_back(mkerr(0, 3'b011, 32'h107));
`endif

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        reset_n = 1'b1;
        step();

        foreach (vecs[i]) run_txn(vecs[i]);

        // Reset while waiting for read data: the late response must be dropped.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_sel = 3'b011; req_addr = 32'h500; req_wdata = 32'd0;
        step();
        req_valid = 1'b0;
        chk("seq_rst_req0", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        step();
        reset_n = 1'b1;
        step();
        chk("seq_rst_no_resp", {31'd0, resp_valid}, 32'd0);
        chk("seq_rst_idle", {31'd0, req_ready}, 32'd1);
        mem_rvalid = 1'b0;
        step();
        chk("seq_rst_no_resp2", {31'd0, resp_valid}, 32'd0);
        run_txn(vecs[0]);

        // Stray rvalid during REQ0 must not advance the beat.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_sel = 3'b011; req_addr = 32'h600; req_wdata = 32'd0;
        step();
        req_valid = 1'b0;
        e.err = 1'b0;
        e.rdata = 32'h11223344;
        sb_q.push_back(e);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFFFFFF;
        step();
        mem_rvalid = 1'b0;
        chk("seq_stray_hold_req", {31'd0, mem_req}, 32'd1);
        chk("seq_stray_hold_addr", mem_addr, 32'h600);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h11223344;
        step();
        mem_rvalid = 1'b0;
        chk("seq_stray_resp", {31'd0, resp_valid}, 32'd1);

        repeat (3) step();
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
